// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle ADD/SUB/ACC/pass ops plus a WIDTH-cycle
// shift-add multiplier, with a valid/ready request side and a result pulse.
module seq_alu #(
  parameter int         WIDTH = 4,
  parameter logic [2:0] OFF   = 3'd0,
  parameter logic [2:0] ADD   = 3'd1,
  parameter logic [2:0] SUB   = 3'd2,
  parameter logic [2:0] NO_OP = 3'd3,
  parameter logic [2:0] ACC   = 3'd4,
  parameter logic [2:0] MUL   = 3'd5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       alu_op,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_hi,
  output logic             flag,
  output logic             out_valid,
  output logic             err
);

  localparam int            CW       = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_DONE = CW'(WIDTH);

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    MUL_BUSY = 1'b1
  } state_t;

  // One multiplier bit per call: conditional add of the multiplicand into
  // the high half, then shift {hi,lo} right; after WIDTH calls {hi,lo}=A*B.
  function automatic logic [2*WIDTH-1:0] mul_step(
    input logic [WIDTH-1:0] hi,
    input logic [WIDTH-1:0] lo,
    input logic [WIDTH-1:0] mcand
  );
    logic [WIDTH:0] sum;
    if (lo[0]) begin
      sum = {1'b0, hi} + {1'b0, mcand};
    end else begin
      sum = {1'b0, hi};
    end
    return {sum[WIDTH:1], sum[0], lo[WIDTH-1:1]};
  endfunction

  state_t             state_r,     state_nx;
  logic [CW-1:0]      cnt_r,       cnt_nx;
  logic [WIDTH-1:0]   mcand_r,     mcand_nx;
  logic [WIDTH-1:0]   hi_r,        hi_nx;
  logic [WIDTH-1:0]   lo_r,        lo_nx;
  logic [WIDTH-1:0]   acc_r,       acc_nx;
  logic [WIDTH-1:0]   out_r,       out_nx;
  logic [WIDTH-1:0]   out_hi_r,    out_hi_nx;
  logic               flag_r,      flag_nx;
  logic               out_valid_r, out_valid_nx;
  logic               err_r,       err_nx;

  logic               in_ready_s;
  logic               accept_s;
  logic [WIDTH:0]     add_sum_s;
  logic [WIDTH:0]     acc_sum_s;

  assign in_ready_s = (state_r == IDLE) && !rst;
  assign accept_s   = in_valid && in_ready_s;
  assign add_sum_s  = {1'b0, A} + {1'b0, B};
  assign acc_sum_s  = {1'b0, acc_r} + {1'b0, A};

  // Next-state and next-output logic for the IDLE / MUL_BUSY controller.
  always_comb begin
    state_nx     = state_r;
    cnt_nx       = cnt_r;
    mcand_nx     = mcand_r;
    hi_nx        = hi_r;
    lo_nx        = lo_r;
    acc_nx       = acc_r;
    out_nx       = out_r;
    out_hi_nx    = out_hi_r;
    flag_nx      = flag_r;
    out_valid_nx = 1'b0;
    err_nx       = 1'b0;

    case (state_r)
      IDLE: begin
        if (accept_s) begin
          case (alu_op)
            OFF: begin
              out_nx       = {WIDTH{1'b0}};
              out_hi_nx    = {WIDTH{1'b0}};
              flag_nx      = 1'b0;
              out_valid_nx = 1'b1;
            end
            ADD: begin
              out_nx       = add_sum_s[WIDTH-1:0];
              out_hi_nx    = {WIDTH{1'b0}};
              flag_nx      = add_sum_s[WIDTH];
              out_valid_nx = 1'b1;
            end
            SUB: begin
              if (A < B) begin
                out_nx  = B - A;
                flag_nx = 1'b1;
              end else begin
                out_nx  = A - B;
                flag_nx = 1'b0;
              end
              out_hi_nx    = {WIDTH{1'b0}};
              out_valid_nx = 1'b1;
            end
            NO_OP: begin
              out_valid_nx = 1'b1;
            end
            ACC: begin
              acc_nx       = acc_sum_s[WIDTH-1:0];
              out_nx       = acc_sum_s[WIDTH-1:0];
              out_hi_nx    = {WIDTH{1'b0}};
              flag_nx      = acc_sum_s[WIDTH];
              out_valid_nx = 1'b1;
            end
            MUL: begin
              // Bit 0 of the multiplier is consumed on the accept edge itself.
              {hi_nx, lo_nx} = mul_step({WIDTH{1'b0}}, B, A);
              mcand_nx       = A;
              cnt_nx         = CNT_ONE;
              state_nx       = MUL_BUSY;
            end
            default: begin
              out_valid_nx = 1'b1;
              err_nx       = 1'b1;
            end
          endcase
        end else begin
          state_nx = IDLE;
        end
      end
      MUL_BUSY: begin
        if (cnt_r == CNT_DONE) begin
          state_nx = IDLE;
        end else begin
          {hi_nx, lo_nx} = mul_step(hi_r, lo_r, mcand_r);
          cnt_nx         = cnt_r + CNT_ONE;
          if (cnt_r == CNT_LAST) begin
            out_nx       = lo_nx;
            out_hi_nx    = hi_nx;
            flag_nx      = |hi_nx;
            out_valid_nx = 1'b1;
          end else begin
            out_valid_nx = 1'b0;
          end
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      cnt_r       <= {CW{1'b0}};
      mcand_r     <= {WIDTH{1'b0}};
      hi_r        <= {WIDTH{1'b0}};
      lo_r        <= {WIDTH{1'b0}};
      acc_r       <= {WIDTH{1'b0}};
      out_r       <= {WIDTH{1'b0}};
      out_hi_r    <= {WIDTH{1'b0}};
      flag_r      <= 1'b0;
      out_valid_r <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      state_r     <= state_nx;
      cnt_r       <= cnt_nx;
      mcand_r     <= mcand_nx;
      hi_r        <= hi_nx;
      lo_r        <= lo_nx;
      acc_r       <= acc_nx;
      out_r       <= out_nx;
      out_hi_r    <= out_hi_nx;
      flag_r      <= flag_nx;
      out_valid_r <= out_valid_nx;
      err_r       <= err_nx;
    end
  end

  assign in_ready  = in_ready_s;
  assign out       = out_r;
  assign out_hi    = out_hi_r;
  assign flag      = flag_r;
  assign out_valid = out_valid_r;
  assign err       = err_r;

endmodule

// File: tb/tb_seq_alu.sv
// Directed, scoreboard-based bench for seq_alu at WIDTH=4: expected results
// are queued with their due cycle and compared when out_valid pulses.
module tb_seq_alu;

  localparam int         W      = 4;
  localparam logic [2:0] OP_OFF = 3'd0;
  localparam logic [2:0] OP_ADD = 3'd1;
  localparam logic [2:0] OP_SUB = 3'd2;
  localparam logic [2:0] OP_NOP = 3'd3;
  localparam logic [2:0] OP_ACC = 3'd4;
  localparam logic [2:0] OP_MUL = 3'd5;
  localparam logic [2:0] OP_IL6 = 3'd6;
  localparam logic [2:0] OP_IL7 = 3'd7;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] A, B;
  logic [2:0]   alu_op;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] out, out_hi;
  logic         flag, out_valid, err;

  seq_alu #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .A(A), .B(B), .alu_op(alu_op),
    .in_valid(in_valid), .in_ready(in_ready), .out(out), .out_hi(out_hi),
    .flag(flag), .out_valid(out_valid), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] o;
    logic [W-1:0] h;
    logic         f;
    logic         e;
    int           due;
  } exp_t;

  exp_t         sb_q[$];
  exp_t         mon_e;
  int           errors = 0;
  int           checks = 0;
  int           cyc    = 0;
  bit           mon_en = 1'b0;
  logic [W-1:0] m_out = '0, m_hi = '0, m_acc = '0;
  logic         m_flag = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Result monitor: pops the scoreboard on each out_valid pulse.
  always @(negedge clk) begin
    if (mon_en) begin
      if (out_valid === 1'b1) begin
        if (sb_q.size() == 0) chk("unexpected_out_valid", out_valid, 0);
        else begin
          mon_e = sb_q.pop_front();
          chk("latency_cycle", cyc, mon_e.due);
          chk("out", out, mon_e.o);
          chk("out_hi", out_hi, mon_e.h);
          chk("flag", flag, mon_e.f);
          chk("err", err, mon_e.e);
        end
      end else begin
        chk("out_valid_known", out_valid, 0);
        chk("err_without_valid", err, 0);
        if (sb_q.size() != 0 && sb_q[0].due <= cyc) begin
          chk("result_missing", out_valid, 1);
          sb_q.delete(0);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_out  = '0;
    m_hi   = '0;
    m_acc  = '0;
    m_flag = 1'b0;
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_out"}, out, 0);
    chk({tag, "_out_hi"}, out_hi, 0);
    chk({tag, "_flag"}, flag, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_err"}, err, 0);
  endtask

  // Drive one request for one cycle and queue the modelled result.
  task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t           e;
    logic [W:0]     s;
    logic [2*W-1:0] p;
    chk("in_ready_idle", in_ready, 1);
    A = a; B = b; alu_op = op; in_valid = 1'b1;
    e.e   = 1'b0;
    e.due = cyc + 1;
    case (op)
      OP_OFF: begin m_out = '0; m_hi = '0; m_flag = 1'b0; end
      OP_ADD: begin
        s = {1'b0, a} + {1'b0, b};
        m_out = s[W-1:0]; m_hi = '0; m_flag = s[W];
      end
      OP_SUB: begin
        if (a < b) begin m_out = b - a; m_flag = 1'b1; end
        else begin m_out = a - b; m_flag = 1'b0; end
        m_hi = '0;
      end
      OP_NOP: begin end
      OP_ACC: begin
        s = {1'b0, m_acc} + {1'b0, a};
        m_acc = s[W-1:0]; m_out = s[W-1:0]; m_hi = '0; m_flag = s[W];
      end
      OP_MUL: begin
        p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        m_out = p[W-1:0]; m_hi = p[2*W-1:W]; m_flag = (p[2*W-1:W] != '0);
        e.due = cyc + W;
      end
      default: e.e = 1'b1;
    endcase
    e.o = m_out; e.h = m_hi; e.f = m_flag;
    sb_q.push_back(e);
    tick();
    in_valid = 1'b0;
  endtask

  // Busy window after a MUL accept; junk requests must be ignored.
  task automatic mul_wait();
    for (int i = 0; i < W; i++) begin
      chk("in_ready_busy", in_ready, 0);
      in_valid = 1'b1; alu_op = OP_ADD; A = 4'd1; B = 4'd1;
      tick();
    end
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; A = '0; B = '0; alu_op = OP_OFF;
    tick();
    tick();
    chk_zero_outputs("reset");
    chk("in_ready_in_reset", in_ready, 0);
    mon_en = 1'b1;
    rst = 1'b0;
    #1;
    chk("in_ready_after_reset", in_ready, 1);

    issue(OP_ADD, 4'd9, 4'd8);
    issue(OP_SUB, 4'd3, 4'd7);
    issue(OP_SUB, 4'd7, 4'd7);
    issue(OP_SUB, 4'd12, 4'd5);

    issue(OP_MUL, 4'd15, 4'd15);
    mul_wait();

    rst = 1'b1; tick(); rst = 1'b0; model_reset(); #1;
    issue(OP_ACC, 4'd9, 4'd3);
    issue(OP_ADD, 4'd1, 4'd2);
    issue(OP_ACC, 4'd9, 4'd0);

    issue(OP_ADD, 4'd2, 4'd3);
    issue(OP_IL6, 4'd1, 4'd1);
    issue(OP_NOP, 4'd4, 4'd4);
    issue(OP_IL7, 4'd2, 4'd2);
    issue(OP_ACC, 4'd1, 4'd0);
    issue(OP_OFF, 4'd6, 4'd6);

    issue(OP_ADD, 4'd4, 4'd4);
    rst = 1'b1; in_valid = 1'b1; alu_op = OP_ADD; A = 4'd7; B = 4'd7;
    #1;
    chk("in_ready_rst_accept", in_ready, 0);
    tick();
    rst = 1'b0; in_valid = 1'b0; model_reset();
    #1;
    chk_zero_outputs("rst_over_accept");
    tick();
    tick();

    issue(OP_ADD, 4'd6, 4'd7);
    issue(OP_MUL, 4'd5, 4'd7);
    tick();
    rst = 1'b1; sb_q.delete();
    tick();
    rst = 1'b0; model_reset();
    #1;
    chk("in_ready_after_abort", in_ready, 1);
    chk_zero_outputs("mul_abort");
    for (int i = 0; i < 6; i++) tick();

    issue(OP_MUL, 4'd3, 4'd5);
    mul_wait();
    issue(OP_MUL, 4'd12, 4'd11);
    mul_wait();
    issue(OP_MUL, 4'd0, 4'd9);
    mul_wait();
    issue(OP_ACC, 4'd1, 4'd0);

    for (int i = 0; i < 4; i++) tick();
    chk("scoreboard_drained", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
